// File: rtl/bram_rd_streamer.sv
// bram_rd_streamer: reads a burst of consecutive words from a single-port BRAM
// with a one-cycle registered read and streams them out on a valid/ready port.
// A 2-entry FIFO absorbs the read latency so that one word per cycle is
// sustained while m_ready stays high.
//
// Ports:
//   a_clk, rst        clock and synchronous active-high reset
//   start             one-cycle burst request, only honoured while idle
//   base_addr, len    first address and word count (0..2**ADDR_WIDTH), taken with start
//   busy, done        burst in progress / one-cycle completion pulse
//   mem_en, mem_addr  BRAM read enable and address (address wraps modulo depth)
//   mem_wr, mem_data_in  BRAM write side, tied off
//   mem_data_out      BRAM read data, valid the cycle after a mem_en edge
//   m_data, m_valid, m_ready, m_last  output stream
module bram_rd_streamer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  a_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic [CNT_W-1:0]        issued_q, issued_d;
    logic                    inflight_q, inflight_d;
    logic                    inflight_last_q, inflight_last_d;

    logic [DATA_WIDTH-1:0]   fifo_data_q [2];
    logic [1:0]              fifo_last_q;
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              occ_q;

    logic                    pop_c;
    logic                    push_c;
    logic                    mem_en_c;
    logic                    head_last_c;
    logic [2:0]              pending_c;

    // Credit check: words held or in flight after this cycle's pop must leave room.
    always_comb begin
        pop_c       = (occ_q != 2'd0) && m_ready;
        push_c      = inflight_q;
        head_last_c = fifo_last_q[rd_ptr_q];
        pending_c   = 3'(occ_q) + 3'(inflight_q) - 3'(pop_c);
        mem_en_c    = (state_q == ST_RUN) && (issued_q < len_q) && (pending_c < 3'd2);
    end

    // Next-state and burst bookkeeping.
    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        len_d           = len_q;
        issued_d        = issued_q;
        inflight_d      = mem_en_c;
        inflight_last_d = mem_en_c && (issued_q == (len_q - CNT_W'(1)));
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    len_d    = len;
                    issued_d = '0;
                    state_d  = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (mem_en_c) begin
                    issued_d = issued_q + CNT_W'(1);
                end
                if (pop_c && head_last_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and control registers.
    always_ff @(posedge a_clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            base_q          <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            len_q           <= len_d;
            issued_q        <= issued_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    // Output FIFO; a word is captured only when a read was issued last cycle,
    // so a read launched just before reset is dropped.
    always_ff @(posedge a_clk) begin
        if (rst) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            occ_q          <= '0;
        end else begin
            if (push_c) begin
                fifo_data_q[wr_ptr_q] <= mem_data_out;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop_c) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_c, pop_c})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign mem_en      = mem_en_c;
    assign mem_addr    = base_q + issued_q[ADDR_WIDTH-1:0];
    assign mem_wr      = 1'b0;
    assign mem_data_in = '0;
    assign m_valid     = (occ_q != 2'd0);
    assign m_data      = fifo_data_q[rd_ptr_q];
    assign m_last      = m_valid && head_last_c;

endmodule

// File: tb/tb_bram_rd_streamer.sv
// Directed bench for bram_rd_streamer with a BRAM model and scoreboard queues
// for issued addresses and streamed words.
module tb_bram_rd_streamer;

    logic       a_clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] base_addr = '0;
    logic [4:0] len = '0;
    logic       busy, done, mem_en, mem_wr, m_valid, m_last;
    logic       m_ready = 1'b1;
    logic [3:0] mem_addr;
    logic [7:0] mem_data_in, m_data;
    logic [7:0] mem_data_out = '0;

    logic [7:0] mem [16];

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t       exp_data[$];
    logic [3:0] exp_addr[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int n_issue = 0;
    int n_pop = 0;
    int first_issue = -1, last_issue = -1, first_xfer = -1, last_xfer = -1;
    int sc;
    logic mon_en = 1'b0;

    bram_rd_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .a_clk(a_clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_wr(mem_wr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 a_clk = ~a_clk;

    // Registered-read BRAM model.
    always @(posedge a_clk) begin
        if (mem_en) mem_data_out <= mem[mem_addr];
    end

    always @(posedge a_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge a_clk) begin
        if (mon_en) begin
            if (busy) chk("occ_plus_inflight_le_2", ((n_issue - n_pop) <= 2) ? 1 : 0, 1);
            if (mem_en) begin
                if (exp_addr.size() == 0) chk("spurious_mem_en", mem_en, 0);
                else chk("mem_addr", mem_addr, exp_addr.pop_front());
                if (first_issue < 0) first_issue = cyc;
                last_issue = cyc;
                n_issue++;
            end
            if (m_valid && m_ready) begin
                if (exp_data.size() == 0) chk("spurious_m_valid", m_valid, 0);
                else begin
                    exp_t e;
                    e = exp_data.pop_front();
                    chk("m_data", m_data, e.d);
                    chk("m_last", m_last, e.l);
                end
                if (first_xfer < 0) first_xfer = cyc;
                last_xfer = cyc;
                n_pop++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge a_clk);
        #2;
    endtask

    task automatic do_start(input int b, input int l);
        for (int k = 0; k < l; k++) begin
            exp_t e;
            logic [3:0] a;
            a = 4'(b + k);
            e.d = mem[a];
            e.l = (k == l - 1);
            exp_addr.push_back(a);
            exp_data.push_back(e);
        end
        first_issue = -1; last_issue = -1; first_xfer = -1; last_xfer = -1;
        sc = cyc;
        start = 1'b1;
        base_addr = 4'(b);
        len = 5'(l);
        step();
        start = 1'b0;
        base_addr = 4'hA;
        len = 5'd3;
    endtask

    task automatic wait_done(input int max, input bit toggle, input bit pulse);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < max; i++) begin
            if (done_cnt != d0) break;
            if (toggle) m_ready = ~m_ready;
            if (pulse) start = busy;
            step();
        end
        start = 1'b0;
        m_ready = 1'b1;
        chk("done_pulse_count", done_cnt - d0, 1);
        chk("scoreboard_drained", exp_data.size(), 0);
        chk("addr_queue_drained", exp_addr.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_mem_wr"}, mem_wr, 0);
        chk({tag, "_mem_data_in"}, mem_data_in, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, i0, d0;
        for (int k = 0; k < 16; k++) mem[k] = 8'(k + 16);

        // Reset state.
        rst = 1'b1;
        repeat (3) step();
        chk_all_zero("reset");
        mon_en = 1'b1;
        rst = 1'b0;
        step();

        // Basic burst, full throughput and latency.
        do_start(3, 4);
        wait_done(40, 1'b0, 1'b0);
        chk("b1_first_issue", first_issue, sc + 1);
        chk("b1_last_issue", last_issue, sc + 4);
        chk("b1_first_xfer", first_xfer, sc + 3);
        chk("b1_last_xfer", last_xfer, sc + 6);
        chk("b1_done_cycle", done_cyc, sc + 7);
        step();

        // Address wrap past the top.
        do_start(14, 4);
        wait_done(40, 1'b0, 1'b0);
        chk("wrap_done_cycle", done_cyc, sc + 7);

        // Full-depth burst with m_ready toggling.
        p0 = n_pop;
        do_start(0, 16);
        wait_done(200, 1'b1, 1'b0);
        chk("full_word_count", n_pop - p0, 16);

        // Zero-length burst.
        i0 = n_issue;
        p0 = n_pop;
        do_start(7, 0);
        wait_done(10, 1'b0, 1'b0);
        chk("len0_done_cycle", done_cyc, sc + 1);
        chk("len0_no_mem_en", n_issue - i0, 0);
        chk("len0_no_m_valid", n_pop - p0, 0);

        // Reset in the middle of a burst, then restart right after reset.
        p0 = n_pop;
        do_start(0, 8);
        for (int i = 0; i < 20; i++) begin
            if (n_pop - p0 >= 2) break;
            step();
        end
        chk("abort_two_words_seen", (n_pop - p0 >= 2) ? 1 : 0, 1);
        d0 = done_cnt;
        rst = 1'b1;
        step();
        exp_data.delete();
        exp_addr.delete();
        n_issue = 0;
        n_pop = 0;
        chk_all_zero("abort");
        step();
        chk("abort_no_done", done_cnt - d0, 0);
        rst = 1'b0;
        do_start(0, 2);
        wait_done(40, 1'b0, 1'b0);
        chk("restart_done_cycle", done_cyc, sc + 5);
        chk("abort_total_done", done_cnt - d0, 1);

        // Start pulses while busy are ignored.
        do_start(5, 6);
        wait_done(60, 1'b0, 1'b1);
        chk("busy_start_done_cycle", done_cyc, sc + 9);
        repeat (3) step();
        chk("busy_start_no_restart", busy, 0);
        chk("busy_start_idle_mem_en", mem_en, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_rd_streamer.md
BRAM_RD_STREAMER -- requirements
Module: bram_rd_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the BRAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, the BRAM address width; depth = 2**ADDR_WIDTH.
REQ-003 a_clk  input  1  clock for all logic; same clock as the attached BRAM port.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin a burst; ignored unless idle.
REQ-006 base_addr  input  ADDR_WIDTH  first word address, sampled with start.
REQ-007 len  input  ADDR_WIDTH+1  word count 0..2**ADDR_WIDTH, sampled with start.
REQ-008 busy  output  1  high from the cycle after an accepted start until done.
REQ-009 done  output  1  one-cycle pulse at burst completion.
REQ-010 mem_en  output  1  BRAM port enable; one read per cycle high.
REQ-011 mem_addr  output  ADDR_WIDTH  BRAM read address.
REQ-012 mem_wr  output  1  BRAM write strobe; constant 0.
REQ-013 mem_data_in  output  DATA_WIDTH  BRAM write data; constant 0.
REQ-014 mem_data_out  input  DATA_WIDTH  BRAM registered read data, valid the cycle after the mem_en edge.
REQ-015 m_data  output  DATA_WIDTH  stream data.
REQ-016 m_valid  output  1  stream valid.
REQ-017 m_ready  input  1  stream ready; a transfer occurs on an edge with m_valid and m_ready both high.
REQ-018 m_last  output  1  high with the final word of a burst.

Function
REQ-019 SHALL implement states IDLE, RUN and DONE.
REQ-020 IDLE -> RUN on start with len != 0; IDLE -> DONE on start with len == 0; base_addr and len latched on the same edge.
REQ-021 RUN -> DONE on the edge transferring the word with m_last; DONE -> IDLE unconditionally after one cycle.
REQ-022 done SHALL be high only in DONE; busy high in RUN and DONE.
REQ-023 Start in RUN or DONE SHALL be ignored with no effect.
REQ-024 In RUN, mem_en SHALL be high when issued < len and (occ + inflight - pop) < 2; occ = output FIFO count, inflight = 1 if mem_en was high last cycle, pop = m_valid & m_ready.
REQ-025 mem_en may be combinational from m_ready; mem_addr SHALL be (base_addr + issued) mod 2**ADDR_WIDTH, so wrap-around past the top address is allowed.
REQ-026 Data SHALL be captured from mem_data_out into a 2-entry FIFO only on edges where inflight = 1; mem_data_out is ignored otherwise.
REQ-027 m_valid = (occ != 0); m_data is the FIFO head; words SHALL leave in address-issue order with no loss or duplication.
REQ-028 Simultaneous FIFO push and pop SHALL keep occ unchanged.
REQ-029 FIFO overflow is impossible by REQ-024.
REQ-030 m_last SHALL be high iff the head word is the len-th word of the burst.
REQ-031 Latency: start sampled at edge E0 -> first mem_en in the cycle after E0 -> m_valid high after edge E2.
REQ-032 With m_ready held high, mem_en and m_valid SHALL sustain one word per cycle.
REQ-033 len = 2**ADDR_WIDTH SHALL read every address exactly once.

Reset
REQ-034 On rst: state IDLE, FIFO flushed, inflight and issued counters cleared, busy/done/mem_en/m_valid/m_last = 0, mem_addr = 0, m_data = 0.
REQ-035 Reset mid-burst SHALL abort the burst without a done pulse, and the read returning after reset SHALL be discarded.
REQ-036 Start SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-037 Preload mem[k]=k+8'h10; base=3, len=4, m_ready=1 -> mem_addr 3,4,5,6 on consecutive cycles; m_data 13,14,15,16 on consecutive cycles; m_last with 16; done the cycle after.
REQ-038 ADDR_WIDTH=4, base=14, len=4 -> addresses 14,15,0,1; data mem[14],mem[15],mem[0],mem[1].
REQ-039 base=0, len=16, m_ready toggling 1,0,1,0 -> 16 ordered words, no duplicates; occ+inflight never exceeds 2; done once.
REQ-040 len=0 -> done pulses the cycle after start; mem_en and m_valid never asserted.
REQ-041 rst asserted after 2 of 8 words -> all outputs 0 the next cycle, no done; new start (base=0, len=2) completes normally.
REQ-042 Start pulses while busy -> ignored; outputs match a single-burst run.
